sap_out_display: RTL and testbench
==================================

SAP_OUT_DISPLAY -- requirements
Module: sap_out_display

Interface
REQ-001 Parameter DATA_W, default 8: width of the output register and of bus_in.
REQ-002 Parameter DIGITS, default 3: number of seven-segment digits scanned; digit 0 is least significant.
REQ-003 Parameter SCAN_DIV, default 4: clock cycles each digit stays enabled; minimum 1.
REQ-004 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-005 Port clr  in  1: reset, asynchronous, active-high.
REQ-006 Port lo  in  1: load-output strobe; captures bus_in on the rising edge of clk.
REQ-007 Port bus_in  in  DATA_W: value to be loaded.
REQ-008 Port mode_dec  in  1: 0 = hexadecimal display, 1 = decimal display; sampled only on a lo edge.
REQ-009 Port out  out  DATA_W: output register contents, binary.
REQ-010 Port seg  out  7: segments {a,b,c,d,e,f,g} on bits 6..0, active-high, for the currently enabled digit.
REQ-011 Port dig_en  out  DIGITS: one-hot digit enable.
REQ-012 Port busy  out  1: high while a conversion is in progress.

Function
REQ-013 A lo edge SHALL load out <= bus_in and start a conversion, with the state going from IDLE to CONV.
REQ-014 Hex conversion SHALL take one CONV cycle and update the digit register on edge N+1, where N is the lo edge.
- Digit k = nibble k of out.
- Digits above ceil(DATA_W/4) = 0.
REQ-015 Decimal conversion SHALL run a shift-add-3 (double-dabble) sequence over DATA_W shift edges, N+1..N+DATA_W, then latch the digit register on edge N+DATA_W+1.
REQ-016 busy SHALL be high from edge N to the latch edge, i.e. 1 cycle in hex mode and DATA_W+1 cycles in decimal mode; it SHALL be low in IDLE.
REQ-017 Until the latch edge the digit register and seg SHALL keep showing the previous value, so the display never shows a partial conversion.
REQ-018 In decimal mode, if out > 10^DIGITS-1, all digits SHALL latch the dash code (seg 0000001) instead of truncated BCD.
REQ-019 A lo during CONV SHALL reload out, abort the current conversion and restart it from edge N; busy SHALL stay high with no gap.
REQ-020 Segment codes SHALL be:
- 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011, 5 = 1011011, 6 = 1011111, 7 = 1110000
- 8 = 1111111, 9 = 1111011, A = 1110111, b = 0011111, C = 1001110, d = 0111101, E = 1001111, F = 1000111
REQ-021 A scan prescaler SHALL count 0..SCAN_DIV-1; on wrap the digit index SHALL advance, wrapping from DIGITS-1 to 0.
REQ-022 dig_en SHALL equal 1 << index.
REQ-023 seg SHALL be the registered code of the digit at the current index; seg and dig_en SHALL change on the same edge.
REQ-024 The scan SHALL run continuously and independently of lo and busy.

Reset
REQ-025 When clr is asserted, without waiting for a clock edge:
- out = 0, all digits = 0, state = IDLE, busy = 0
- prescaler = 0, index = 0, dig_en = 1, seg = 1111110
REQ-026 clr asserted mid-conversion SHALL discard the conversion, with no digit update after release.
REQ-027 The first lo after clr release SHALL behave exactly as REQ-013.

Structure
REQ-028 Package sap_pkg SHALL hold:
- state encoding IDLE/CONV/LATCH
- the 16 segment constants
- the dash constant
REQ-029 One sub-module, seg7_encode, SHALL be used: combinational 4-bit code to 7-bit segments, including the dash code.
REQ-030 Parameters SHALL be checked at elaboration: DATA_W>=4, DIGITS>=1, SCAN_DIV>=1.

Verification (defaults unless stated)
REQ-031 Decimal, lo with bus_in=255 -> out=255 on edge N; busy high for 9 cycles; then digits 2,5,5 (seg 1101101, 1011011, 1011011).
REQ-032 Hex, lo with bus_in=8'hA7 -> busy high for 1 cycle; digits 0,A,7 (seg 1111110, 1110111, 1110000).
REQ-033 DIGITS=2, decimal, lo with 200 -> both digits show 0000001; lo with 99 -> 9,9.
REQ-034 Decimal, lo with 100, then lo with 42 three cycles later -> busy continuous; final display 0,4,2; digit value 100 never displayed.
REQ-035 SCAN_DIV=4 -> dig_en sequence 001 x4, 010 x4, 100 x4, 001, with seg matching each digit.
REQ-036 clr pulse at conversion cycle 4, mid-clock -> outputs reach reset values immediately; display stays 0,0,0 after release.

Source files
------------

// File: rtl/sap_pkg.sv
// sap_pkg: shared definitions for the SAP output/display block.
//   sap_state_e : conversion FSM states (IDLE, CONV, LATCH)
//   SEG_0..SEG_F: active-high {a,b,c,d,e,f,g} codes for hex digits
//   SEG_DASH    : overflow indicator (segment g only)
package sap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        LATCH = 2'd2
    } sap_state_e;

    localparam logic [6:0] SEG_0    = 7'b1111110;
    localparam logic [6:0] SEG_1    = 7'b0110000;
    localparam logic [6:0] SEG_2    = 7'b1101101;
    localparam logic [6:0] SEG_3    = 7'b1111001;
    localparam logic [6:0] SEG_4    = 7'b0110011;
    localparam logic [6:0] SEG_5    = 7'b1011011;
    localparam logic [6:0] SEG_6    = 7'b1011111;
    localparam logic [6:0] SEG_7    = 7'b1110000;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1111011;
    localparam logic [6:0] SEG_A    = 7'b1110111;
    localparam logic [6:0] SEG_B    = 7'b0011111;
    localparam logic [6:0] SEG_C    = 7'b1001110;
    localparam logic [6:0] SEG_D    = 7'b0111101;
    localparam logic [6:0] SEG_E    = 7'b1001111;
    localparam logic [6:0] SEG_F    = 7'b1000111;
    localparam logic [6:0] SEG_DASH = 7'b0000001;

endpackage

// File: rtl/sap_out_display_seg7_encode.sv
// seg7_encode: combinational digit-to-segment decoder.
//   code : 4-bit digit value (0..F)
//   dash : when high, overrides code and shows the dash pattern
//   seg  : {a,b,c,d,e,f,g}, active-high
module seg7_encode
    import sap_pkg::*;
(
    input  logic [3:0] code,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_0;
        if (dash) begin
            seg = SEG_DASH;
        end else begin
            case (code)
                4'h0: seg = SEG_0;
                4'h1: seg = SEG_1;
                4'h2: seg = SEG_2;
                4'h3: seg = SEG_3;
                4'h4: seg = SEG_4;
                4'h5: seg = SEG_5;
                4'h6: seg = SEG_6;
                4'h7: seg = SEG_7;
                4'h8: seg = SEG_8;
                4'h9: seg = SEG_9;
                4'hA: seg = SEG_A;
                4'hB: seg = SEG_B;
                4'hC: seg = SEG_C;
                4'hD: seg = SEG_D;
                4'hE: seg = SEG_E;
                default: seg = SEG_F;
            endcase
        end
    end

endmodule

// File: rtl/sap_out_display.sv
// sap_out_display: SAP output register with multiplexed 7-segment display.
//   clk, clr        : clock, asynchronous active-high reset
//   lo, bus_in      : load strobe and value captured into the output register
//   mode_dec        : 0 = hex display, 1 = decimal display (sampled with lo)
//   out             : output register contents
//   seg, dig_en     : segments of the enabled digit, one-hot digit enable
//   busy            : conversion in progress
module sap_out_display
    import sap_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              lo,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mode_dec,
    output logic [DATA_W-1:0] out,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] dig_en,
    output logic              busy
);

    if (DATA_W < 4) begin : g_chk_data_w
        $error("sap_out_display: DATA_W must be >= 4");
    end
    if (DIGITS < 1) begin : g_chk_digits
        $error("sap_out_display: DIGITS must be >= 1");
    end
    if (SCAN_DIV < 1) begin : g_chk_scan_div
        $error("sap_out_display: SCAN_DIV must be >= 1");
    end

    localparam int NH   = (DATA_W + 3) / 4;          // hex nibbles in out
    localparam int NBCD = (DATA_W + 2) / 3;          // BCD digits able to hold 2^DATA_W-1
    localparam int NB   = (NBCD > DIGITS) ? NBCD : DIGITS;
    localparam int HW   = 4 * ((NH > DIGITS) ? NH : DIGITS);
    localparam int BW   = 4 * NB;
    localparam int CW   = $clog2(DATA_W);
    localparam int PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef logic [4:0] digit_t;                     // {dash, code}

    sap_state_e          state_q, state_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                mode_q, mode_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    digit_t [DIGITS-1:0] digits_q, digits_d;
    logic                busy_q, busy_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [DIGITS-1:0]   dig_en_q, dig_en_d;
    logic [6:0]          seg_q, seg_d;

    logic [HW-1:0]       out_pad;
    logic [BW-1:0]       bcd_adj;
    logic                overflow;
    digit_t              sel_digit;

    // Double-dabble helpers; BCD digits beyond DIGITS flag an overflow.
    always_comb begin
        out_pad = '0;
        out_pad[DATA_W-1:0] = out_q;
        bcd_adj = bcd_q;
        for (int unsigned k = 0; k < NB; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
        overflow = 1'b0;
        for (int unsigned k = DIGITS; k < NB; k++) begin
            overflow = overflow | (|bcd_q[4*k +: 4]);
        end
    end

    // Conversion FSM. The digit register only changes on the final edge of a
    // conversion, so the display never shows intermediate BCD state.
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        mode_d   = mode_q;
        shreg_d  = shreg_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        if (lo) begin
            out_d   = bus_in;
            mode_d  = mode_dec;
            shreg_d = bus_in;
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = CONV;
        end else begin
            case (state_q)
                CONV: begin
                    if (!mode_q) begin
                        for (int unsigned k = 0; k < DIGITS; k++) begin
                            digits_d[k] = {1'b0, out_pad[4*k +: 4]};
                        end
                        state_d = IDLE;
                    end else begin
                        bcd_d   = BW'({bcd_adj, shreg_q[DATA_W-1]});
                        shreg_d = shreg_q << 1;
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == CW'(DATA_W - 1)) begin
                            state_d = LATCH;
                        end
                    end
                end
                LATCH: begin
                    for (int unsigned k = 0; k < DIGITS; k++) begin
                        digits_d[k] = overflow ? 5'b1_0000 : {1'b0, bcd_q[4*k +: 4]};
                    end
                    state_d = IDLE;
                end
                default: ;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    // Scan: seg is encoded from next-cycle digit and index so seg and dig_en
    // move together and a freshly latched digit appears on the latch edge.
    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        sel_digit = '0;
        dig_en_d  = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx_d == IW'(k)) begin
                sel_digit   = digits_d[k];
                dig_en_d[k] = 1'b1;
            end
        end
    end

    seg7_encode u_seg7_encode (
        .code (sel_digit[3:0]),
        .dash (sel_digit[4]),
        .seg  (seg_d)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            out_q    <= '0;
            mode_q   <= 1'b0;
            shreg_q  <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            digits_q <= '0;
            busy_q   <= 1'b0;
            presc_q  <= '0;
            idx_q    <= '0;
            dig_en_q <= DIGITS'(1);
            seg_q    <= SEG_0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            mode_q   <= mode_d;
            shreg_q  <= shreg_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            busy_q   <= busy_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            dig_en_q <= dig_en_d;
            seg_q    <= seg_d;
        end
    end

    assign out    = out_q;
    assign seg    = seg_q;
    assign dig_en = dig_en_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_sap_out_display.sv
// tb_sap_out_display: self-checking bench for sap_out_display.
// A DIGITS=3 instance is checked every cycle against a behavioural model
// (digit values from integer division, scan index from the edge count);
// a DIGITS=2 instance covers decimal overflow.
module tb_sap_out_display;

    logic       clk = 1'b0;
    logic       clr, lo, mode_dec, lo2, mode2;
    logic [7:0] bus_in, bus2, out, out2;
    logic [6:0] seg, seg2;
    logic [2:0] dig_en;
    logic [1:0] dig_en2;
    logic       busy, busy2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sap_out_display #(.DATA_W(8), .DIGITS(3), .SCAN_DIV(4)) u_dut (
        .clk(clk), .clr(clr), .lo(lo), .bus_in(bus_in), .mode_dec(mode_dec),
        .out(out), .seg(seg), .dig_en(dig_en), .busy(busy)
    );

    sap_out_display #(.DATA_W(8), .DIGITS(2), .SCAN_DIV(4)) u_dut2 (
        .clk(clk), .clr(clr), .lo(lo2), .bus_in(bus2), .mode_dec(mode2),
        .out(out2), .seg(seg2), .dig_en(dig_en2), .busy(busy2)
    );

    typedef struct {
        logic [7:0] bus;
        bit         dec;
        int         busy_cyc;
        logic [6:0] s2, s1, s0;
    } vec_t;

    vec_t vecs[10];
    logic [2:0] scan_exp[13];

    // Reference model state
    int e;
    int m_out;
    int m_dig[3];
    int p_dig[3];
    bit pend;
    int latch_at;

    function automatic logic [6:0] seg_of(int d);
        case (d)
            0:  return 7'b1111110;
            1:  return 7'b0110000;
            2:  return 7'b1101101;
            3:  return 7'b1111001;
            4:  return 7'b0110011;
            5:  return 7'b1011011;
            6:  return 7'b1011111;
            7:  return 7'b1110000;
            8:  return 7'b1111111;
            9:  return 7'b1111011;
            10: return 7'b1110111;
            11: return 7'b0011111;
            12: return 7'b1001110;
            13: return 7'b0111101;
            14: return 7'b1001111;
            15: return 7'b1000111;
            default: return 7'b0000001;
        endcase
    endfunction

    // -1 denotes the dash
    function automatic int digit_of(int val, bit dec, int ndig, int k);
        if (!dec) return (val >> (4 * k)) & 15;
        if (val > 10 ** ndig - 1) return -1;
        return (val / (10 ** k)) % 10;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        e = 0; m_out = 0; pend = 0;
        for (int k = 0; k < 3; k++) m_dig[k] = 0;
    endtask

    task automatic model_edge();
        if (clr) begin
            model_reset();
        end else begin
            e++;
            if (lo) begin
                m_out = bus_in;
                for (int k = 0; k < 3; k++) p_dig[k] = digit_of(int'(bus_in), mode_dec, 3, k);
                latch_at = e + (mode_dec ? 9 : 1);
                pend = 1;
            end else if (pend && e == latch_at) begin
                for (int k = 0; k < 3; k++) m_dig[k] = p_dig[k];
                pend = 0;
            end
        end
    endtask

    task automatic check_all();
        int idx;
        idx = (e / 4) % 3;
        chk("out", int'(out), m_out);
        chk("busy", int'(busy), int'(pend));
        chk("dig_en", int'(dig_en), 1 << idx);
        chk("seg", int'(seg), int'(seg_of(m_dig[idx])));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_digit(int k, logic [6:0] exp, string name);
        int w;
        w = 0;
        while (dig_en != 3'(1 << k) && w < 20) begin
            step();
            w++;
        end
        chk({name, "_wait"}, int'(w < 20), 1);
        chk(name, int'(seg), int'(exp));
    endtask

    task automatic apply_vec(vec_t v);
        int cnt;
        bus_in = v.bus; mode_dec = v.dec; lo = 1'b1;
        step();
        lo = 1'b0;
        chk("load_out", int'(out), int'(v.bus));
        cnt = 0;
        while (busy && cnt < 50) begin
            cnt++;
            step();
        end
        chk("busy_cycles", cnt, v.busy_cyc);
        wait_digit(0, v.s0, "vec_d0");
        wait_digit(1, v.s1, "vec_d1");
        wait_digit(2, v.s2, "vec_d2");
    endtask

    initial begin
        int cnt, gap;
        vecs[0] = '{8'd255,  1'b1, 9, 7'b1101101, 7'b1011011, 7'b1011011};
        vecs[1] = '{8'hA7,   1'b0, 1, 7'b1111110, 7'b1110111, 7'b1110000};
        vecs[2] = '{8'd128,  1'b1, 9, 7'b0110000, 7'b1101101, 7'b1111111};
        vecs[3] = '{8'hFF,   1'b0, 1, 7'b1111110, 7'b1000111, 7'b1000111};
        vecs[4] = '{8'h3C,   1'b0, 1, 7'b1111110, 7'b1111001, 7'b1001110};
        vecs[5] = '{8'hDB,   1'b0, 1, 7'b1111110, 7'b0111101, 7'b0011111};
        vecs[6] = '{8'd0,    1'b1, 9, 7'b1111110, 7'b1111110, 7'b1111110};
        vecs[7] = '{8'd9,    1'b1, 9, 7'b1111110, 7'b1111110, 7'b1111011};
        vecs[8] = '{8'd230,  1'b1, 9, 7'b1101101, 7'b1111001, 7'b1111110};
        vecs[9] = '{8'h6E,   1'b0, 1, 7'b1111110, 7'b1011111, 7'b1001111};
        scan_exp = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010,
                     3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001};

        clr = 1'b1; lo = 1'b0; mode_dec = 1'b0; bus_in = '0;
        lo2 = 1'b0; mode2 = 1'b0; bus2 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_out", int'(out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_dig_en", int'(dig_en), 1);
        chk("rst_seg", int'(seg), 7'b1111110);
        chk("rst_dig_en2", int'(dig_en2), 1);
        chk("rst_seg2", int'(seg2), 7'b1111110);
        clr = 1'b0;

        // Scan order straight out of reset
        for (int i = 1; i < 13; i++) begin
            step();
            chk("scan_seq", int'(dig_en), int'(scan_exp[i]));
        end

        for (int v = 0; v < 10; v++) apply_vec(vecs[v]);

        // Reload 3 cycles into a decimal conversion: no busy gap, 100 never shown
        bus_in = 8'd100; mode_dec = 1'b1; lo = 1'b1;
        step();
        lo = 1'b0;
        cnt = 1; gap = 0;
        repeat (2) begin
            step();
            if (busy) cnt++; else gap++;
        end
        bus_in = 8'd42; lo = 1'b1;
        step();
        lo = 1'b0;
        if (busy) cnt++; else gap++;
        while (busy && cnt < 60) begin
            step();
            if (busy) cnt++;
        end
        chk("reload_gap", gap, 0);
        chk("reload_busy_cycles", cnt, 12);
        chk("reload_out", int'(out), 42);
        wait_digit(0, 7'b1101101, "reload_d0");
        wait_digit(1, 7'b0110011, "reload_d1");
        wait_digit(2, 7'b1111110, "reload_d2");

        // Two-digit instance: decimal overflow shows dashes, 99 fits
        bus2 = 8'd200; mode2 = 1'b1; lo2 = 1'b1;
        step();
        lo2 = 1'b0;
        repeat (12) step();
        chk("d2_out", int'(out2), 200);
        chk("d2_busy", int'(busy2), 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("d2_dash", int'(seg2), 7'b0000001);
        end
        bus2 = 8'd99; lo2 = 1'b1;
        step();
        lo2 = 1'b0;
        repeat (12) step();
        for (int i = 0; i < 8; i++) begin
            step();
            chk("d2_99", int'(seg2), 7'b1111011);
        end

        // Asynchronous clear in the middle of a decimal conversion
        bus_in = 8'd255; mode_dec = 1'b1; lo = 1'b1;
        step();
        lo = 1'b0;
        repeat (4) step();
        #2 clr = 1'b1;
        #1;
        chk("aclr_out", int'(out), 0);
        chk("aclr_busy", int'(busy), 0);
        chk("aclr_dig_en", int'(dig_en), 1);
        chk("aclr_seg", int'(seg), 7'b1111110);
        model_reset();
        step();
        clr = 1'b0;
        repeat (15) step();
        chk("aclr_busy_after", int'(busy), 0);
        wait_digit(0, 7'b1111110, "aclr_d0");
        wait_digit(1, 7'b1111110, "aclr_d1");
        wait_digit(2, 7'b1111110, "aclr_d2");

        // Random loads in both modes, including reloads mid-conversion
        repeat (300) begin
            bus_in   = 8'($urandom_range(0, 255));
            mode_dec = 1'($urandom_range(0, 1));
            lo       = ($urandom_range(0, 3) == 0);
            step();
        end
        lo = 1'b0;
        repeat (12) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
